cpu5_lsu: RTL and testbench

CPU5_LSU -- requirements
Module: cpu5_lsu

---
 rtl/cpu5_lsu_pkg.sv | 56 +++++
 rtl/cpu5_lsu_if.sv | 36 +++
 rtl/cpu5_lsu_align.sv | 41 ++++
 rtl/cpu5_lsu.sv | 134 +++++++++++++
 tb/tb_cpu5_lsu.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu5_lsu_pkg.sv
// Shared definitions for the cpu5 load/store unit: access sizes, FSM encoding
// and the small per-request helper functions used by the LSU.
package cpu5_lsu_pkg;

    localparam int CPU5_XLEN = 32;

    localparam int         CPU5_LSU_SIZE_WIDTH = 2;
    localparam logic [1:0] CPU5_LSU_SIZE_B     = 2'd0;
    localparam logic [1:0] CPU5_LSU_SIZE_H     = 2'd1;
    localparam logic [1:0] CPU5_LSU_SIZE_W     = 2'd2;

    localparam int CPU5_LSU_STATE_WIDTH = 2;

    typedef enum logic [CPU5_LSU_STATE_WIDTH-1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Size 3 is not a legal access and is reported as a fault like misalignment.
    function automatic logic lsu_misaligned(input logic [CPU5_LSU_SIZE_WIDTH-1:0] size,
                                            input logic [1:0]                     addr_lo);
        logic result;
        case (size)
            CPU5_LSU_SIZE_B: result = 1'b0;
            CPU5_LSU_SIZE_H: result = addr_lo[0];
            CPU5_LSU_SIZE_W: result = (addr_lo != 2'b00);
            default:         result = 1'b1;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [CPU5_LSU_SIZE_WIDTH-1:0] size,
                                               input logic [1:0]                     addr_lo);
        logic [3:0] be;
        case (size)
            CPU5_LSU_SIZE_B: be = 4'b0001 << addr_lo;
            CPU5_LSU_SIZE_H: be = 4'b0011 << {addr_lo[1], 1'b0};
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across every lane so the byte enables alone pick the target.
    function automatic logic [CPU5_XLEN-1:0] lsu_store_data(input logic [CPU5_LSU_SIZE_WIDTH-1:0] size,
                                                            input logic [CPU5_XLEN-1:0]           wdata);
        logic [CPU5_XLEN-1:0] data;
        case (size)
            CPU5_LSU_SIZE_B: data = {4{wdata[7:0]}};
            CPU5_LSU_SIZE_H: data = {2{wdata[15:0]}};
            default:         data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/cpu5_lsu_if.sv
// Word-wide memory bus between the LSU (master) and the data memory (slave).
interface cpu5_lsu_if
    import cpu5_lsu_pkg::*;
#(
    parameter int XLEN = CPU5_XLEN
) ();

    logic            mem_valid;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/cpu5_lsu_align.sv
// Combinational load alignment: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it to XLEN.
module cpu5_lsu_align
    import cpu5_lsu_pkg::*;
#(
    parameter int XLEN = CPU5_XLEN
) (
    input  logic [XLEN-1:0]                mem_rdata,
    input  logic [CPU5_LSU_SIZE_WIDTH-1:0] size,
    input  logic                           is_unsigned,
    input  logic [1:0]                     offset,
    output logic [XLEN-1:0]                load_data
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = mem_rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = mem_rdata[16*gi +: 16];
        end
    endgenerate

    assign byte_sel = byte_lane[offset];
    assign half_sel = half_lane[offset[1]];

    always_comb begin
        load_data = mem_rdata;
        case (size)
            CPU5_LSU_SIZE_B: load_data = {{(XLEN-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            CPU5_LSU_SIZE_H: load_data = {{(XLEN-16){~is_unsigned & half_sel[15]}}, half_sel};
            default:         load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/cpu5_lsu.sv
// cpu5 load/store unit: one aligned access at a time, IDLE -> BUS -> DONE,
// with misaligned/illegal requests faulted immediately without a bus cycle.
module cpu5_lsu
    import cpu5_lsu_pkg::*;
#(
    parameter int XLEN = CPU5_XLEN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [CPU5_LSU_SIZE_WIDTH-1:0] req_size,
    input  logic                           req_unsigned,
    input  logic [XLEN-1:0]                req_addr,
    input  logic [XLEN-1:0]                req_wdata,
    output logic                           stall,
    output logic [XLEN-1:0]                rdata,
    output logic                           misalign,
    cpu5_lsu_if.master                     bus
);

    lsu_state_t state_reg;
    lsu_state_t state_next;

    logic                           we_reg;
    logic [CPU5_LSU_SIZE_WIDTH-1:0] size_reg;
    logic                           unsigned_reg;
    logic [1:0]                     offset_reg;
    logic [XLEN-1:0]                addr_reg;
    logic [3:0]                     be_reg;
    logic [XLEN-1:0]                wdata_reg;
    logic [XLEN-1:0]                rdata_reg;

    logic            req_misaligned;
    logic            capture;
    logic            rdata_load;
    logic [XLEN-1:0] load_data;

    assign req_misaligned = lsu_misaligned(req_size, req_addr[1:0]);

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        rdata_load = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        case (state_reg)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        state_next = LSU_BUS;
                    end
                end
            end
            LSU_BUS: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    rdata_load = ~we_reg;
                    state_next = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_next = LSU_IDLE;
            end
            default: begin
                state_next = LSU_IDLE;
            end
        endcase
        // Combinational outputs must not follow the inputs while reset is held.
        if (reset) begin
            stall    = 1'b0;
            misalign = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= LSU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request is latched once on acceptance so the bus stays stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_reg       <= 1'b0;
            size_reg     <= CPU5_LSU_SIZE_B;
            unsigned_reg <= 1'b0;
            offset_reg   <= 2'b00;
            addr_reg     <= '0;
            be_reg       <= 4'b0000;
            wdata_reg    <= '0;
        end else if (capture) begin
            we_reg       <= req_we;
            size_reg     <= req_size;
            unsigned_reg <= req_unsigned;
            offset_reg   <= req_addr[1:0];
            addr_reg     <= {req_addr[XLEN-1:2], 2'b00};
            be_reg       <= lsu_byte_en(req_size, req_addr[1:0]);
            wdata_reg    <= lsu_store_data(req_size, req_wdata);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (rdata_load) begin
            rdata_reg <= load_data;
        end
    end

    cpu5_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .mem_rdata   (bus.mem_rdata),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .offset      (offset_reg),
        .load_data   (load_data)
    );

    assign rdata         = rdata_reg;
    assign bus.mem_valid = (state_reg == LSU_BUS) && !reset;
    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_be    = be_reg;

endmodule

// File: tb/tb_cpu5_lsu.sv
// Directed bench for cpu5_lsu: transaction-level model of expected bus and
// core-side behaviour, compared against the DUT on every falling clock edge.
module tb_cpu5_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign;

    cpu5_lsu_if bus_if ();

    cpu5_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rdata        (rdata),
        .misalign     (misalign),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int stall_cycles;

    // expected outputs, owned by the stimulus thread
    bit          exp_stall;
    bit          exp_misalign;
    bit          exp_valid;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;

    // last bus values observed while mem_valid was high
    logic [3:0]  last_be;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: byte arithmetic on the access ----
    function automatic bit m_mis(input int size, input int addr);
        if (size == 3) return 1'b1;
        return (addr % (1 << size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input int size, input int addr);
        int n;
        int off;
        logic [3:0] be;
        n   = 1 << size;
        off = addr % 4;
        be  = 4'b0000;
        for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = 1 << size;
        r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input int size, input bit uns, input int addr,
                                           input logic [31:0] word);
        int     n;
        int     off;
        longint v;
        n   = 1 << size;
        off = addr % 4;
        v   = longint'(word >> (8 * off));
        if (n < 4) begin
            v = v & ((longint'(1) << (8 * n)) - 1);
            if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        end
        return 32'(v);
    endfunction

    // One core access; waits = mem_ready-low cycles before the handshake.
    task automatic access(input bit we, input int size, input bit uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int waits,
                          input bit hold_in_done);
        bit mis;
        mis = m_mis(size, int'(addr));
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rword=%h waits=%0d",
                 we, size, uns, addr, wdata, word, waits);
        stall_cycles  = 0;
        req_valid     = 1'b1;
        req_we        = we;
        req_size      = 2'(size);
        req_unsigned  = uns;
        req_addr      = addr;
        req_wdata     = wdata;
        bus_if.mem_rdata = word;
        bus_if.mem_ready = 1'b0;
        if (mis) begin
            exp_stall    = 1'b0;
            exp_misalign = 1'b1;
            exp_valid    = 1'b0;
            @(posedge clk); #1;
            req_valid    = 1'b0;
            exp_misalign = 1'b0;
            @(posedge clk); #1;
            chk("fault_stall_cycles", 32'(stall_cycles), 32'd0);
            return;
        end
        exp_stall    = 1'b1;
        exp_misalign = 1'b0;
        exp_valid    = 1'b0;
        exp_we       = we;
        exp_addr     = addr & 32'hFFFF_FFFC;
        exp_be       = m_be(size, int'(addr));
        exp_wdata    = m_wdata(size, wdata);
        @(posedge clk); #1;
        exp_valid = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
        end
        bus_if.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.mem_ready = 1'b0;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        if (!we) exp_rdata = m_load(size, uns, int'(addr), word);
        req_valid = hold_in_done;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_cycles", 32'(stall_cycles), 32'(waits + 2));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        stall_cycles = 0;
        reset = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;
        exp_stall = 1'b0;
        exp_misalign = 1'b0;
        exp_valid = 1'b0;
        exp_we = 1'b0;
        exp_addr = '0;
        exp_be = '0;
        exp_wdata = '0;
        exp_rdata = '0;
        last_be = '0;
        last_addr = '0;
        last_wdata = '0;
        #1 reset = 1'b1;

        fork
            begin
                forever begin
                    @(negedge clk);
                    if (stall) stall_cycles++;
                    chk("stall", 32'(stall), 32'(exp_stall));
                    chk("misalign", 32'(misalign), 32'(exp_misalign));
                    chk("mem_valid", 32'(bus_if.mem_valid), 32'(exp_valid));
                    chk("rdata", rdata, exp_rdata);
                    if (bus_if.mem_valid) begin
                        last_be    = bus_if.mem_be;
                        last_addr  = bus_if.mem_addr;
                        last_wdata = bus_if.mem_wdata;
                    end
                    if (exp_valid) begin
                        chk("mem_we", 32'(bus_if.mem_we), 32'(exp_we));
                        chk("mem_addr", bus_if.mem_addr, exp_addr);
                        chk("mem_be", 32'(bus_if.mem_be), 32'(exp_be));
                        chk("mem_wdata", bus_if.mem_wdata, exp_wdata);
                    end
                end
            end
        join_none

        // reset state, with a request held on the inputs
        req_valid = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0104;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
        chk("rst_mem_be", 32'(bus_if.mem_be), 32'h0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
        chk("rst_mem_we", 32'(bus_if.mem_we), 32'h0);
        req_valid = 1'b0;
        reset = 1'b0;

        // hand-computed pins on the model itself
        chk("model_be_sb", 32'(m_be(0, 'h103)), 32'h8);
        chk("model_wdata_sb", m_wdata(0, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("model_lb", m_load(0, 1'b0, 'h102, 32'h1280_5634), 32'hFFFF_FF80);
        chk("model_lbu", m_load(0, 1'b1, 'h102, 32'h1280_5634), 32'h0000_0080);
        chk("model_lh_mis", 32'(m_mis(1, 'h101)), 32'h1);

        @(posedge clk); #1;

        access(1'b1, 2, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        chk("sw_be", 32'(last_be), 32'hF);
        chk("sw_addr", last_addr, 32'h100);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);

        access(1'b1, 0, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 0, 1'b0);
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);

        access(1'b0, 0, 1'b0, 32'h102, 32'h0, 32'h1280_5634, 0, 1'b0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        access(1'b0, 0, 1'b1, 32'h102, 32'h0, 32'h1280_5634, 0, 1'b0);
        chk("lbu_rdata", rdata, 32'h0000_0080);

        access(1'b0, 1, 1'b0, 32'h101, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
        chk("lh_mis_rdata_kept", rdata, 32'h0000_0080);

        access(1'b0, 1, 1'b0, 32'h102, 32'h0, 32'h8001_7FFF, 1, 1'b0);
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        access(1'b0, 1, 1'b1, 32'h100, 32'h0, 32'h8001_7FFF, 0, 1'b0);
        access(1'b1, 1, 1'b0, 32'h102, 32'h1234_BEEF, 32'h0, 2, 1'b0);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);

        access(1'b0, 2, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 5, 1'b1);
        chk("lw_wait_rdata", rdata, 32'hCAFE_F00D);

        access(1'b0, 3, 1'b0, 32'h200, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 2, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 0, 1'b1, 32'h203, 32'h0, 32'hF1E2_D3C4, 0, 1'b0);
        access(1'b0, 0, 1'b0, 32'h200, 32'h0, 32'hF1E2_D37C, 0, 1'b0);
        access(1'b1, 2, 1'b0, 32'h300, 32'h0102_0304, 32'h0, 0, 1'b0);
        chk("store_keeps_rdata", rdata, 32'h0000_007C);

        // reset in the middle of a bus transfer
        $display("txn reset during BUS: LW addr=00000040");
        req_valid = 1'b1;
        req_we = 1'b0;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_addr = 32'h40;
        bus_if.mem_ready = 1'b0;
        exp_stall = 1'b1;
        exp_we = 1'b0;
        exp_addr = 32'h40;
        exp_be = 4'hF;
        exp_wdata = 32'h0102_0304;
        req_wdata = 32'h0102_0304;
        @(posedge clk); #1;
        exp_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_stall = 1'b0;
        exp_valid = 1'b0;
        exp_rdata = '0;
        #1;
        chk("rst_bus_valid", 32'(bus_if.mem_valid), 32'h0);
        chk("rst_bus_stall", 32'(stall), 32'h0);
        chk("rst_bus_rdata", rdata, 32'h0);
        chk("rst_bus_be", 32'(bus_if.mem_be), 32'h0);
        chk("rst_bus_addr", bus_if.mem_addr, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 2, 1'b0, 32'h8, 32'h0, 32'h5566_7788, 0, 1'b0);
        chk("post_rst_lw", rdata, 32'h5566_7788);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
